// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Single-outstanding memory access controller. It accepts one
//                read or write request from the control FSM, drives a
//                request/acknowledge memory bus, and reports completion with
//                a one-cycle done pulse. If no acknowledge arrives within
//                TIMEOUT_CYC bus cycles, the access ends with err set.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    rd_req     in   read request (memory-read enable)
//    wr_req     in   write request (MemWrite); takes priority over rd_req
//    addr       in   [AW]   byte address of the access
//    wdata      in   [DW]   write data
//    wstrb      in   [DW/8] byte-lane write enables
//    busy       out  high whenever the controller is not idle
//    done       out  one-cycle completion pulse
//    rdata      out  [DW]   last successfully read data
//    err        out  access ended by timeout (valid with done)
//    bus_req    out  memory request, held until ack or timeout
//    bus_we     out  1 = write, 0 = read
//    bus_addr   out  [AW]   word-aligned address
//    bus_wdata  out  [DW]   write data to memory
//    bus_wstrb  out  [DW/8] byte enables to memory (zero on reads)
//    bus_ack    in   memory completion strobe
//    bus_rdata  in   [DW]   memory read data, valid with bus_ack
// ============================================================================
module mem_access_ctrl #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req,
    input  logic            wr_req,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata
);

    // A one-cycle timeout still needs a 1-bit counter to exist.
    localparam int              c_cnt_w     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
    // Clears address bits [1:0] to produce a word-aligned bus address.
    localparam logic [AW-1:0]   c_word_mask = ~(AW'(3));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [AW-1:0]       r_bus_addr;
    logic [DW-1:0]       r_bus_wdata;
    logic [DW/8-1:0]     r_bus_wstrb;
    logic [DW-1:0]       r_rdata;
    logic                r_err;

    logic                w_start;
    logic                w_ack;
    logic                w_timeout;

    // Requests are only looked at in IDLE; anything arriving while busy is dropped.
    assign w_start   = (r_state == ST_IDLE) && (rd_req || wr_req);
    assign w_ack     = (r_state == ST_BUS)  && bus_ack;
    // An ack on the final wait cycle wins over the timeout.
    assign w_timeout = (r_state == ST_BUS)  && !bus_ack && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)              w_state_nxt = ST_BUS;
            ST_BUS:  if (w_ack || w_timeout)   w_state_nxt = ST_DONE;
            ST_DONE:                           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus interface, timeout counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else if (w_start) begin
            // Write wins when both requests are present.
            r_cnt       <= '0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= wr_req;
            r_bus_addr  <= addr & c_word_mask;
            r_bus_wdata <= wdata;
            r_bus_wstrb <= wr_req ? wstrb : '0;
        end else if (w_ack) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b0;
            if (!r_bus_we) begin
                r_rdata <= bus_rdata;
            end
        end else if (w_timeout) begin
            // rdata keeps the last good read value.
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
        end else if (r_state == ST_BUS) begin
            // Stops at c_cnt_last because that value always leaves BUS.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;

endmodule
`default_nettype wire
